clock_edge_tracker: RTL

- Receiving end of a divided or slow clock. Samples a slow clock signal (for example a divider output or an external peripheral clock) in the clock_in domain.
- Synchronizes it and emits single-cycle rise/fall enable pulses.
- Measures the period in clock_in cycles and reports lock once the period is stable.
- Downstream logic uses the pulses as clock enables instead of clocking on the divided signal.

---
 rtl/clock_edge_tracker_pkg.sv | 23 ++
 rtl/clock_edge_tracker_edge_sync.sv | 52 +++++
 rtl/clock_edge_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/clock_edge_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_edge_tracker_pkg
// Brief    : Shared state encoding and default sizing for the slow-clock tracker.
// Revision : 1.0
// ============================================================================
package clock_edge_tracker_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PW          = 8;
  localparam int DEF_LOCK_COUNT  = 4;
  localparam int DEF_TOL         = 1;

  localparam logic [DEF_PW-1:0] CNT_MAX = {DEF_PW{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/clock_edge_tracker_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : clock_edge_tracker_edge_sync
// Brief    : Synchronizes the slow clock and produces rise/fall strobes.
// Revision : 1.0
// ============================================================================
module clock_edge_tracker_edge_sync
  import clock_edge_tracker_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clock_in,
  input  logic reset,
  input  logic clk_sample_i,
  output logic sync_o,
  output logic rise_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   rise_pulse_q;
  logic                   fall_pulse_q;
  logic                   fall_w;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], clk_sample_i};
  assign sync_o = sync_q[SYNC_STAGES-1];
  // Unregistered rise feeds the period counter and FSM in the same cycle.
  assign rise_o = sync_o & ~prev_q;
  assign fall_w = ~sync_o & prev_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= sync_o;
      rise_pulse_q <= rise_o;
      fall_pulse_q <= fall_w;
    end
  end

  assign rise_pulse_o = rise_pulse_q;
  assign fall_pulse_o = fall_pulse_q;

endmodule
`default_nettype wire

// File: rtl/clock_edge_tracker.sv
`default_nettype none
// ============================================================================
// Module   : clock_edge_tracker
// Brief    : Tracks a slow clock: edge enables, period measurement and lock.
// Revision : 1.0
// ============================================================================
module clock_edge_tracker
  import clock_edge_tracker_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PW          = DEF_PW,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int TOL         = DEF_TOL
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          clk_sample,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          lost
);

  localparam int            MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] C_CNT_MAX = {PW{1'b1}};
  localparam logic [MW-1:0] C_LOCK    = MW'(LOCK_COUNT);
  localparam logic [PW:0]   C_TOL     = (PW+1)'(TOL);

  logic sync_unused;
  logic rise_int;

  state_e        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ref_q, ref_d;
  logic          ref_valid_q, ref_valid_d;
  logic [MW-1:0] match_q, match_d;
  logic [PW-1:0] period_q, period_d;
  logic          period_valid_q, period_valid_d;
  logic          locked_q, locked_d;
  logic          lost_q, lost_d;

  logic [PW:0]   diff_w;
  logic          in_tol_w;
  logic [MW-1:0] match_inc_w;
  logic          cnt_sat_w;

  clock_edge_tracker_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock_in     (clock_in),
    .reset        (reset),
    .clk_sample_i (clk_sample),
    .sync_o       (sync_unused),
    .rise_o       (rise_int),
    .rise_pulse_o (rise_pulse),
    .fall_pulse_o (fall_pulse)
  );

  // One extra bit keeps the absolute difference from wrapping.
  assign diff_w      = (cnt_q >= ref_q) ? ({1'b0, cnt_q} - {1'b0, ref_q})
                                        : ({1'b0, ref_q} - {1'b0, cnt_q});
  assign in_tol_w    = (diff_w <= C_TOL);
  assign match_inc_w = match_q + 1'b1;
  assign cnt_sat_w   = (cnt_q == C_CNT_MAX);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ref_d          = ref_q;
    ref_valid_d    = ref_valid_q;
    match_d        = match_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    lost_d         = 1'b0;

    if (rise_int) begin
      cnt_d = {{(PW-1){1'b0}}, 1'b1};
    end else if (!cnt_sat_w) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      SEARCH: begin
        if (rise_int) begin
          state_d     = ACQUIRE;
          ref_valid_d = 1'b0;
        end
      end
      ACQUIRE: begin
        if (rise_int) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (!ref_valid_q) begin
            ref_d       = cnt_q;
            ref_valid_d = 1'b1;
            match_d     = MW'(1);
          end else if (in_tol_w) begin
            match_d = match_inc_w;
            if (match_inc_w == C_LOCK) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = MW'(1);
          end
        end else if (cnt_sat_w) begin
          lost_d   = 1'b1;
          locked_d = 1'b0;
          state_d  = SEARCH;
        end
      end
      LOCKED: begin
        if (rise_int) begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          // The reference stays frozen while rises remain in tolerance.
          if (!in_tol_w) begin
            locked_d = 1'b0;
            ref_d    = cnt_q;
            match_d  = MW'(1);
            state_d  = ACQUIRE;
          end
        end else if (cnt_sat_w) begin
          lost_d   = 1'b1;
          locked_d = 1'b0;
          state_d  = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q        <= SEARCH;
      cnt_q          <= '0;
      ref_q          <= '0;
      ref_valid_q    <= 1'b0;
      match_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ref_q          <= ref_d;
      ref_valid_q    <= ref_valid_d;
      match_q        <= match_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule
`default_nettype wire
